sha256_msa_scheduler: RTL and testbench
=======================================

# sha256_msa_scheduler

Round-robin scheduler that shares one SHA-256 message-schedule extender between `NUM_REQ` hash-job requesters. It accepts one (context, chunk) job at a time from the winning requester and sequences the extender's context, chunk and W handshakes. It forwards the 64-word expanded schedule, the context and a requester tag to the compression stage. The extender is not pipelined, so exactly one job is in flight.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `TAG_W`, `$clog2(NUM_REQ)`: tag width.
- `TIMEOUT`, 63: max cycles in `WAIT_W` before the job is abandoned; 1..255.
- `clk  in  1  clock`
- `rst  in  1  reset (synchronous, active-high)`
- `req_vld  in  NUM_REQ  per-requester job valid`
- `req_rdy  out  NUM_REQ  one-hot job accept`
- `req_ctx  in  NUM_REQ x sha256_pkg::ShaContext  per-requester context`
- `req_chunk  in  NUM_REQ x [15:0][31:0]  per-requester 512-bit chunk`
- `ext_ctx_vld / ext_ctx_rdy  out / in  1  extender context handshake`
- `ext_ctx  out  ShaContext  held context`
- `ext_chunk_vld / ext_chunk_rdy  out / in  1  extender chunk handshake`
- `ext_chunk_data  out  [15:0][31:0]  held chunk`
- `ext_w_vld / ext_w_rdy  in / out  1  extender W handshake`
- `ext_w  in  [63:0][31:0]  expanded schedule`
- `out_vld / out_rdy  out / in  1  downstream handshake`
- `out_w  out  [63:0][31:0]`, `out_ctx  out  ShaContext`, `out_tag  out  TAG_W`: result fields.
- `busy  out  1  state != IDLE`
- `timeout_err  out  1  sticky; set on timeout, cleared only by rst`

## Operation
- FSM: `IDLE`, `ISSUE`, `WAIT_W`, `OUTPUT`.
- `IDLE`:
  - Combinational round-robin grant `g` = first `i` with `req_vld[i]`, searching from `rr_ptr` upward and wrapping at `NUM_REQ-1`.
  - `req_rdy[g]`=1 combinationally in the same cycle; all other bits are 0.
  - On the transfer, capture `req_ctx[g]`, `req_chunk[g]` and tag=`g`.
  - Set `rr_ptr` to `(g+1) mod NUM_REQ`, then go to `ISSUE`.
  - If no `req_vld` is set, stay in `IDLE`.
- `ISSUE`:
  - `ext_ctx_vld` = ~`ctx_done` and `ext_chunk_vld` = ~`chunk_done`.
  - Each done flag sets on its own vld&rdy; the two handshakes are independent and may complete in either order or the same cycle.
  - When both flags are set (including a same-cycle final handshake), clear them and go to `WAIT_W`.
- `WAIT_W`:
  - `ext_w_rdy`=1 combinationally. The cycle counter `tcnt` starts at 0 on entry and increments each cycle.
  - On `ext_w_vld`, capture `ext_w`, the held ctx and the tag into the output registers and go to `OUTPUT`.
  - Else, if `tcnt`==`TIMEOUT-1`, set `timeout_err`, drop the job and go to `IDLE`.
  - `ext_w_vld` takes priority in the cycle the timeout would fire.
- `OUTPUT`:
  - `out_vld`=1, with fields stable until `out_rdy`.
  - On `out_rdy`, go to `IDLE`. A new grant can occur the following cycle.
- Holding registers and `ext_ctx`/`ext_chunk_data` change only on a `req_rdy` transfer.
- `rst` mid-operation: all state is abandoned and there is no partial output. The extender must be reset by the same `rst`.

## Timing
- Reset values: state=`IDLE`, `rr_ptr`=0, `req_rdy`=0, `ext_*_vld`=0, `ext_w_rdy`=0, `out_vld`=0, `busy`=0, `timeout_err`=0.
- `out_w`/`out_ctx`/`out_tag` are 0 after reset.
- Minimum latency: accept in cycle T; `ISSUE` at T+1. With both rdys at T+1, `WAIT_W` at T+2. With `ext_w_vld` at T+2, `out_vld` at T+3.
- Throughput is bounded by the extender (one job in flight). There is no bubble between an `out_rdy` handshake and `IDLE`.
- `req_rdy` is asserted only in `IDLE` and is never asserted for more than one requester.
- A requester dropping `req_vld` without a handshake is legal; grant is re-evaluated every `IDLE` cycle.

## Test plan
- Single job, req 2 valid, all rdys high → `req_rdy`=4'b0100 at T; `out_vld` at T+3 with `out_tag`=2 and `out_w` equal to the golden schedule for chunk "abc"-padded (`out_w[16]`=0x61626380-based reference value).
- All four `req_vld` held high → grant order 0,1,2,3,0; `rr_ptr` wraps 3→0.
- Req 1 and req 3 valid with `rr_ptr`=2 → req 3 granted first, then req 1.
- `ext_chunk_rdy` delayed 5 cycles after `ext_ctx_rdy` → `ext_ctx_vld` drops after its handshake, `ext_chunk_vld` held 6 cycles, `WAIT_W` entered once.
- `ext_w_vld` never asserted with `TIMEOUT`=63 → `timeout_err`=1 exactly 63 cycles after `WAIT_W` entry, state `IDLE`, no `out_vld`.
- `out_rdy`=0 for 10 cycles, then `rst` asserted in `OUTPUT` → fields stable while waiting; after `rst`, `out_vld`=0, `busy`=0, `rr_ptr`=0.

Source files
------------

// File: rtl/sha256_msa_scheduler.sv
// Round-robin arbiter feeding one shared SHA-256 message-schedule extender; forwards W[0..63], context and tag.
// Latency: accept at T, ISSUE T+1, WAIT_W T+2, out_vld T+3 when the extender and downstream are always ready.
// Backpressure: one job in flight; req_rdy only in IDLE, results held stable until out_rdy.

package sha256_pkg;
  // Running hash state carried next to a chunk through schedule expansion and compression.
  typedef struct packed {
    logic [7:0][31:0] h;
    logic [31:0]      blk_idx;
  } ShaContext;
endpackage

module sha256_msa_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = $clog2(NUM_REQ),
  parameter int TIMEOUT = 63
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_REQ-1:0]                    req_vld,
  output logic [NUM_REQ-1:0]                    req_rdy,
  input  sha256_pkg::ShaContext [NUM_REQ-1:0]   req_ctx,
  input  logic [NUM_REQ-1:0][15:0][31:0]        req_chunk,
  output logic                                  ext_ctx_vld,
  input  logic                                  ext_ctx_rdy,
  output sha256_pkg::ShaContext                 ext_ctx,
  output logic                                  ext_chunk_vld,
  input  logic                                  ext_chunk_rdy,
  output logic [15:0][31:0]                     ext_chunk_data,
  input  logic                                  ext_w_vld,
  output logic                                  ext_w_rdy,
  input  logic [63:0][31:0]                     ext_w,
  output logic                                  out_vld,
  input  logic                                  out_rdy,
  output logic [63:0][31:0]                     out_w,
  output sha256_pkg::ShaContext                 out_ctx,
  output logic [TAG_W-1:0]                      out_tag,
  output logic                                  busy,
  output logic                                  timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_W, OUTPUT} state_t;

  localparam logic [7:0]       TMO_LAST  = 8'(TIMEOUT - 1);
  localparam logic [TAG_W:0]   NUM_REQ_W = (TAG_W + 1)'(NUM_REQ);
  localparam logic [TAG_W-1:0] LAST_REQ  = TAG_W'(NUM_REQ - 1);

  state_t                state, state_nxt;
  logic [TAG_W-1:0]      rr_ptr;
  logic [TAG_W-1:0]      grant_idx;
  logic                  grant_any;
  logic [TAG_W:0]        grant_sum;
  logic [TAG_W-1:0]      hold_tag;
  sha256_pkg::ShaContext hold_ctx;
  logic [15:0][31:0]     hold_chunk;
  logic                  ctx_done, chunk_done;
  logic [7:0]            tcnt;

  logic accept, ctx_hs, chunk_hs, issue_done, w_hs, tmo_fire;

  // A transfer needs IDLE and a valid requester; reset masks req_rdy so nothing is accepted mid-reset.
  assign accept     = (state == IDLE) && grant_any && !rst;
  assign ctx_hs     = ext_ctx_vld && ext_ctx_rdy;
  assign chunk_hs   = ext_chunk_vld && ext_chunk_rdy;
  assign issue_done = (ctx_done || ctx_hs) && (chunk_done || chunk_hs);
  assign w_hs       = ext_w_vld && ext_w_rdy;
  assign tmo_fire   = (state == WAIT_W) && !ext_w_vld && (tcnt == TMO_LAST);

  assign ext_ctx        = hold_ctx;
  assign ext_chunk_data = hold_chunk;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping at NUM_REQ-1.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    grant_sum = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      grant_sum = {1'b0, rr_ptr} + (TAG_W + 1)'(k);
      if (grant_sum >= NUM_REQ_W) grant_sum = grant_sum - NUM_REQ_W;
      if (!grant_any && req_vld[grant_sum[TAG_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = grant_sum[TAG_W-1:0];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: W arrival wins over a timeout landing in the same cycle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)     state_nxt = ISSUE;
      ISSUE:   if (issue_done) state_nxt = WAIT_W;
      WAIT_W:  if (w_hs)       state_nxt = OUTPUT;
               else if (tcnt == TMO_LAST) state_nxt = IDLE;
      OUTPUT:  if (out_rdy)    state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state and the per-channel done flags.
  always_comb begin
    req_rdy       = '0;
    ext_ctx_vld   = 1'b0;
    ext_chunk_vld = 1'b0;
    ext_w_rdy     = 1'b0;
    out_vld       = 1'b0;
    busy          = (state != IDLE);
    if (accept) req_rdy = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx;
    if (state == ISSUE) begin
      ext_ctx_vld   = !ctx_done;
      ext_chunk_vld = !chunk_done;
    end
    if (state == WAIT_W) ext_w_rdy = 1'b1;
    if (state == OUTPUT) out_vld = 1'b1;
  end

  // Job capture, issue bookkeeping, timeout counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= '0;
      hold_tag    <= '0;
      hold_ctx    <= '0;
      hold_chunk  <= '0;
      ctx_done    <= 1'b0;
      chunk_done  <= 1'b0;
      tcnt        <= '0;
      out_w       <= '0;
      out_ctx     <= '0;
      out_tag     <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (accept) begin
        hold_ctx   <= req_ctx[grant_idx];
        hold_chunk <= req_chunk[grant_idx];
        hold_tag   <= grant_idx;
        rr_ptr     <= (grant_idx == LAST_REQ) ? '0 : grant_idx + 1'b1;
      end
      if (state == ISSUE) begin
        if (issue_done) begin
          ctx_done   <= 1'b0;
          chunk_done <= 1'b0;
        end else begin
          if (ctx_hs)   ctx_done   <= 1'b1;
          if (chunk_hs) chunk_done <= 1'b1;
        end
      end
      tcnt <= (state == WAIT_W) ? tcnt + 1'b1 : '0;
      if (w_hs) begin
        out_w   <= ext_w;
        out_ctx <= hold_ctx;
        out_tag <= hold_tag;
      end
      if (tmo_fire) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sha256_msa_scheduler.sv
module tb_sha256_msa_scheduler;
  import sha256_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int TAG_W   = 2;
  localparam int TIMEOUT = 63;

  logic                            clk = 1'b0;
  logic                            rst = 1'b1;
  logic [NUM_REQ-1:0]              req_vld = '0;
  logic [NUM_REQ-1:0]              req_rdy;
  ShaContext [NUM_REQ-1:0]         req_ctx;
  logic [NUM_REQ-1:0][15:0][31:0]  req_chunk;
  logic                            ext_ctx_vld, ext_chunk_vld, ext_w_rdy;
  logic                            ext_ctx_rdy = 1'b1;
  logic                            ext_chunk_rdy = 1'b1;
  ShaContext                       ext_ctx;
  logic [15:0][31:0]               ext_chunk_data;
  logic                            ext_w_vld;
  logic [63:0][31:0]               ext_w;
  logic                            out_vld;
  logic                            out_rdy = 1'b1;
  logic [63:0][31:0]               out_w;
  ShaContext                       out_ctx;
  logic [TAG_W-1:0]                out_tag;
  logic                            busy, timeout_err;

  sha256_msa_scheduler #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_ctx(req_ctx), .req_chunk(req_chunk),
    .ext_ctx_vld(ext_ctx_vld), .ext_ctx_rdy(ext_ctx_rdy), .ext_ctx(ext_ctx),
    .ext_chunk_vld(ext_chunk_vld), .ext_chunk_rdy(ext_chunk_rdy), .ext_chunk_data(ext_chunk_data),
    .ext_w_vld(ext_w_vld), .ext_w_rdy(ext_w_rdy), .ext_w(ext_w),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_w(out_w), .out_ctx(out_ctx), .out_tag(out_tag),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int fails = 0;
  int wait_entries = 0;

  typedef struct {
    logic [TAG_W-1:0]  tag;
    ShaContext         ctx;
    logic [63:0][31:0] w;
  } exp_t;
  exp_t sb_q[$];

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference SHA-256 message schedule.
  function automatic logic [63:0][31:0] expand(input logic [15:0][31:0] m);
    logic [63:0][31:0] w;
    logic [31:0] s0, s1;
    w = '0;
    for (int t = 0; t < 16; t++) w[t] = m[t];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    return w;
  endfunction

  // Behavioural extender: latches the chunk on its handshake, offers W when enabled.
  logic [15:0][31:0] model_chunk = '0;
  logic              ext_pending;
  logic              w_vld_en = 1'b1;

  always @(posedge clk) begin
    if (rst) ext_pending <= 1'b0;
    else if (ext_chunk_vld && ext_chunk_rdy) begin
      ext_pending <= 1'b1;
      model_chunk <= ext_chunk_data;
    end else if (ext_w_vld && ext_w_rdy) ext_pending <= 1'b0;
  end

  assign ext_w_vld = ext_pending && w_vld_en;
  assign ext_w     = expand(model_chunk);

  // Scoreboard: every downstream handshake must match the oldest expected job.
  always @(negedge clk) begin
    if (!rst && out_vld && out_rdy) begin
      tests_run++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: got output tag=%0d, required no output", out_tag);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (out_tag !== e.tag || out_ctx !== e.ctx || out_w !== e.w) begin
          fails++;
          $display("FAIL sb_out: got tag=%0d blk=%h w16=%h w63=%h, required tag=%0d blk=%h w16=%h w63=%h",
                   out_tag, out_ctx.blk_idx, out_w[16], out_w[63], e.tag, e.ctx.blk_idx, e.w[16], e.w[63]);
        end
      end
    end
  end

  // Count WAIT_W entries as rising edges of ext_w_rdy.
  logic prev_w_rdy = 1'b0;
  always @(negedge clk) begin
    if (ext_w_rdy && !prev_w_rdy) wait_entries++;
    prev_w_rdy = ext_w_rdy;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int g);
    exp_t e;
    e.tag = TAG_W'(g);
    e.ctx = req_ctx[g];
    e.w   = expand(req_chunk[g]);
    sb_q.push_back(e);
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    #1;
    while (req_rdy == '0 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_vld = 4'hF;
    tick();
    tick();
    tests_run++; if (req_rdy !== 4'b0) begin fails++; $display("FAIL rst_req_rdy: got %b, required 0000", req_rdy); end
    tests_run++; if ({ext_ctx_vld, ext_chunk_vld, ext_w_rdy} !== 3'b000) begin fails++; $display("FAIL rst_ext: got %b, required 000", {ext_ctx_vld, ext_chunk_vld, ext_w_rdy}); end
    tests_run++; if (out_vld !== 1'b0) begin fails++; $display("FAIL rst_out_vld: got %b, required 0", out_vld); end
    tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b, required 0", busy); end
    tests_run++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL rst_timeout_err: got %b, required 0", timeout_err); end
    tests_run++; if (out_w !== '0 || out_ctx !== '0 || out_tag !== '0) begin fails++; $display("FAIL rst_fields: got w0=%h blk=%h tag=%0d, required 0", out_w[0], out_ctx.blk_idx, out_tag); end
    tests_run++; if (dut.rr_ptr !== 2'd0) begin fails++; $display("FAIL rst_rr_ptr: got %0d, required 0", dut.rr_ptr); end
    req_vld = '0;
    rst = 1'b0;
  endtask

  task automatic test_single();
    req_vld = 4'b0100;
    #1;
    tests_run++; if (req_rdy !== 4'b0100) begin fails++; $display("FAIL single_grant: got %b, required 0100", req_rdy); end
    push_exp(2);
    tick();
    req_vld = '0;
    tests_run++; if ({busy, ext_ctx_vld, ext_chunk_vld} !== 3'b111) begin fails++; $display("FAIL single_issue: got %b, required 111", {busy, ext_ctx_vld, ext_chunk_vld}); end
    tests_run++; if (ext_chunk_data !== req_chunk[2] || ext_ctx !== req_ctx[2]) begin fails++; $display("FAIL single_held: got w0=%h, required %h", ext_chunk_data[0], req_chunk[2][0]); end
    tick();
    tests_run++; if ({ext_w_rdy, out_vld} !== 2'b10) begin fails++; $display("FAIL single_wait: got %b, required 10", {ext_w_rdy, out_vld}); end
    tick();
    tests_run++; if (out_vld !== 1'b1 || out_tag !== 2'd2) begin fails++; $display("FAIL single_out: got vld=%b tag=%0d, required vld=1 tag=2", out_vld, out_tag); end
    tests_run++; if (out_w[16] !== 32'h61626380 || out_w[17] !== 32'h000F0000) begin fails++; $display("FAIL single_golden: got w16=%h w17=%h, required 61626380 000f0000", out_w[16], out_w[17]); end
    tick();
    tests_run++; if ({busy, out_vld} !== 2'b00) begin fails++; $display("FAIL single_done: got %b, required 00", {busy, out_vld}); end
  endtask

  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_rdy;
    int n;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_vld = 4'hF;
    for (int j = 0; j < 5; j++) begin
      wait_grant(n);
      exp_rdy = 4'b0001 << order[j];
      tests_run++; if (req_rdy !== exp_rdy || n >= 20) begin fails++; $display("FAIL rr_order_%0d: got %b after %0d cycles, required %b", j, req_rdy, n, exp_rdy); end
      push_exp(order[j]);
      tick();
      if (j == 3) begin
        tests_run++; if (dut.rr_ptr !== 2'd0) begin fails++; $display("FAIL rr_wrap: got %0d, required 0", dut.rr_ptr); end
      end
    end
    req_vld = '0;
    wait_idle(n);
    tests_run++; if (n >= 40) begin fails++; $display("FAIL rr_drain: got busy after %0d cycles, required idle", n); end
  endtask

  task automatic test_rr_skip();
    int n;
    req_vld = 4'b0010;
    wait_grant(n);
    push_exp(1);
    tick();
    req_vld = '0;
    wait_idle(n);
    tests_run++; if (dut.rr_ptr !== 2'd2) begin fails++; $display("FAIL skip_ptr: got %0d, required 2", dut.rr_ptr); end
    req_vld = 4'b1010;
    wait_grant(n);
    tests_run++; if (req_rdy !== 4'b1000 || n >= 20) begin fails++; $display("FAIL skip_first: got %b, required 1000", req_rdy); end
    push_exp(3);
    tick();
    wait_grant(n);
    tests_run++; if (req_rdy !== 4'b0010 || n >= 20) begin fails++; $display("FAIL skip_second: got %b, required 0010", req_rdy); end
    push_exp(1);
    tick();
    req_vld = '0;
    wait_idle(n);
  endtask

  task automatic test_chunk_delay();
    int e0, chunk_cnt, ctx_bad;
    e0 = wait_entries;
    chunk_cnt = 0;
    ctx_bad = 0;
    ext_chunk_rdy = 1'b0;
    req_vld = 4'b0001;
    #1;
    tests_run++; if (req_rdy !== 4'b0001) begin fails++; $display("FAIL delay_grant: got %b, required 0001", req_rdy); end
    push_exp(0);
    tick();
    req_vld = '0;
    for (int c = 0; c < 10; c++) begin
      if (ext_chunk_vld) chunk_cnt++;
      if (c >= 1 && ext_ctx_vld) ctx_bad++;
      if (c == 5) ext_chunk_rdy = 1'b1;
      tick();
    end
    tests_run++; if (chunk_cnt != 6) begin fails++; $display("FAIL delay_chunk_vld: got %0d cycles, required 6", chunk_cnt); end
    tests_run++; if (ctx_bad != 0) begin fails++; $display("FAIL delay_ctx_drop: got %0d extra cycles, required 0", ctx_bad); end
    tests_run++; if (wait_entries - e0 != 1) begin fails++; $display("FAIL delay_wait_once: got %0d entries, required 1", wait_entries - e0); end
  endtask

  task automatic test_timeout();
    int n, out_seen;
    out_seen = 0;
    w_vld_en = 1'b0;
    req_vld = 4'b0010;
    #1;
    tests_run++; if (req_rdy !== 4'b0010) begin fails++; $display("FAIL tmo_grant: got %b, required 0010", req_rdy); end
    tick();
    req_vld = '0;
    tick();
    tests_run++; if (ext_w_rdy !== 1'b1) begin fails++; $display("FAIL tmo_wait_entry: got %b, required 1", ext_w_rdy); end
    n = 0;
    while (!timeout_err && n < 100) begin
      if (out_vld) out_seen++;
      tick();
      n++;
    end
    tests_run++; if (n != TIMEOUT) begin fails++; $display("FAIL tmo_cycles: got %0d, required %0d", n, TIMEOUT); end
    tests_run++; if ({busy, out_vld} !== 2'b00 || out_seen != 0) begin fails++; $display("FAIL tmo_drop: got busy/vld=%b outs=%0d, required 00 and 0", {busy, out_vld}, out_seen); end
    tick();
    tick();
    tests_run++; if (timeout_err !== 1'b1) begin fails++; $display("FAIL tmo_sticky: got %b, required 1", timeout_err); end
    w_vld_en = 1'b1;
  endtask

  task automatic test_hold_reset();
    int n;
    logic [63:0][31:0] exp_w;
    exp_w = expand(req_chunk[2]);
    out_rdy = 1'b0;
    req_vld = 4'b0100;
    wait_grant(n);
    tick();
    req_vld = '0;
    n = 0;
    while (!out_vld && n < 20) begin
      tick();
      n++;
    end
    tests_run++; if (out_vld !== 1'b1) begin fails++; $display("FAIL hold_reach: got vld=%b, required 1", out_vld); end
    for (int c = 0; c < 10; c++) begin
      tests_run++;
      if (out_vld !== 1'b1 || out_tag !== 2'd2 || out_w !== exp_w || out_ctx !== req_ctx[2]) begin
        fails++;
        $display("FAIL hold_stable_%0d: got vld=%b tag=%0d w16=%h, required vld=1 tag=2 w16=%h", c, out_vld, out_tag, out_w[16], exp_w[16]);
      end
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_rdy = 1'b1;
    tests_run++; if ({out_vld, busy} !== 2'b00) begin fails++; $display("FAIL hold_rst_state: got %b, required 00", {out_vld, busy}); end
    tests_run++; if (dut.rr_ptr !== 2'd0 || timeout_err !== 1'b0 || out_tag !== 2'd0) begin fails++; $display("FAIL hold_rst_regs: got ptr=%0d err=%b tag=%0d, required 0", dut.rr_ptr, timeout_err, out_tag); end
  endtask

  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_chunk[i] = '0;
      req_chunk[i][0]  = (i == 2) ? 32'h61626380 : (32'hA5A50000 | 32'(i));
      req_chunk[i][3]  = 32'h01010101 * 32'(i);
      req_chunk[i][15] = 32'h00000018;
      for (int k = 0; k < 8; k++) req_ctx[i].h[k] = {8'(i), 24'(k)};
      req_ctx[i].blk_idx = 32'(i + 100);
    end
    test_reset();
    test_single();
    test_round_robin();
    test_rr_skip();
    test_chunk_delay();
    test_timeout();
    test_hold_reset();
    tests_run++; if (sb_q.size() != 0) begin fails++; $display("FAIL sb_leftover: got %0d pending, required 0", sb_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
